bcd_display_feeder: RTL and testbench
=====================================

// Module: bcd_display_feeder
// PURPOSE
//  Sequential binary-to-BCD converter that produces the 24-bit packed digit word
//  and per-digit enables consumed by segs_ctrl (Data / DisplayEnables inputs).
//  A binary value (e.g. CPU register or counter) is converted by shift-add-3
//  (double dabble), one bit per clock. Leading zeros are blanked and an overflow
//  marker is shown. Sits directly upstream of segs_ctrl in the display path.
// PARAMETERS
//  VALUE_WIDTH    20      binary input width; also the number of shift iterations
//  DIGITS         6       BCD digits produced; Data width = 4*DIGITS
//  MAX_VALUE      999999  largest displayable value; above this -> overflow
//  BLANK_LEADING  1       1 = blank leading zeros, 0 = enable all digits
// PORTS
//  Clock           in   1              system clock, rising edge
//  Reset           in   1              asynchronous, active-high
//  Start           in   1              request conversion of Value; sampled in IDLE only
//  Value           in   VALUE_WIDTH    unsigned binary to convert; sampled with Start
//  DigitMask       in   DIGITS         user enable mask (switches), ANDed into enables
//  Data            out  4*DIGITS       packed BCD, digit 0 = Data[3:0] (least significant)
//  DisplayEnables  out  DIGITS         per-digit enable to segs_ctrl, bit i = digit i
//  Busy            out  1              conversion in progress; Start ignored while high
//  Done            out  1              one-cycle pulse: Data/DisplayEnables just updated
//  Overflow        out  1              last completed conversion had Value > MAX_VALUE
// BEHAVIOUR
//  Reset (async, any state, incl. mid-conversion): state IDLE; Data=0, Busy=0,
//   Done=0, Overflow=0, enable register=0 (so DisplayEnables=0, all blank);
//   shift register, iteration counter and latched value cleared. Conversion aborted.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE:  Start=1 at edge k -> latch Value and overflow compare (Value>MAX_VALUE),
//          clear BCD accumulator, counter=0, go to SHIFT; Busy=1 from edge k.
//   SHIFT: each edge, every 4-bit accumulator digit >=5 gets +3 (all digits in
//          parallel, same cycle), then {acc,val} shifts left 1 with the val MSB
//          entering acc[0]. Counter increments. Exactly VALUE_WIDTH iterations
//          (edges k+1..k+20); the last iteration moves to DONE.
//   DONE:  edge k+21 -> Data<=acc (or all 4'hF digits if overflow), enable
//          register updated, Overflow<=latched compare, Done=1 for that cycle only,
//          Busy=0, go to IDLE.
//  Latency: Start edge k -> Data/Done valid after edge k+VALUE_WIDTH+1 (k+21).
//   Throughput: next Start accepted at edge k+22 at earliest.
//  Start while Busy (SHIFT or DONE, incl. edge k+21) is ignored, not queued.
//   Value changes during conversion have no effect.
//  Data, Overflow and enable register hold between conversions (display stable).
//  Enables: digit 0 always on; digit i (i>0) on iff BLANK_LEADING=0 or any digit
//   j>=i is nonzero. Overflow: all digits on.
//   DisplayEnables = enable_reg & DigitMask (combinational AND, mask live).
//  Width rules: acc is 4*DIGITS bits; MAX_VALUE < 2**VALUE_WIDTH and
//   < 10**DIGITS. Inputs up to 2**VALUE_WIDTH-1 are legal; values above
//   MAX_VALUE are flagged as overflow, never wrapped.
// TESTING
//  1 Value=0, Start, mask=6'h3F -> Done at k+21, Data=24'h000000, DisplayEnables=6'b000001.
//  2 Value=123456 -> Data=24'h123456, DisplayEnables=6'b111111, Overflow=0;
//    then mask=6'b000011 -> DisplayEnables=6'b000011 immediately, Data unchanged.
//  3 Value=1000 -> Data=24'h001000, enables 6'b001111; Value=999999 -> 24'h999999,
//    Overflow=0; Value=1000000 -> Data=24'hFFFFFF, enables 6'b111111, Overflow=1.
//  4 Start held high continuously, Value 42 then 7 changed mid-conversion ->
//    conversions at k and k+22 only, first Data=24'h000042, Busy low only in IDLE.
//  5 Reset asserted async at k+10 mid-conversion -> all outputs 0 immediately,
//    no Done pulse; new Start after release converts correctly (Value=5 -> 24'h000005).
//  6 Random Values over 1000 conversions vs reference model: Data, enables and
//    Overflow match; Done exactly one cycle per accepted Start.

Source files
------------

// File: rtl/bcd_display_feeder.sv
// Sequential double-dabble binary-to-BCD converter feeding a seven-segment controller.
// Produces packed BCD digits, leading-zero-blanked digit enables and an overflow marker.
module bcd_display_feeder #(
  parameter int unsigned VALUE_WIDTH   = 20,
  parameter int unsigned DIGITS        = 6,
  parameter int unsigned MAX_VALUE     = 999999,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic [DIGITS-1:0]      digit_mask_i,
  output logic [4*DIGITS-1:0]    data_o,
  output logic [DIGITS-1:0]      display_enables_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
  localparam logic [VALUE_WIDTH-1:0] MaxVal  = VALUE_WIDTH'(MAX_VALUE);
  localparam logic [CntW-1:0]        LastCnt = CntW'(VALUE_WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ovf_pend_q, ovf_pend_d;
  logic [AccW-1:0]        data_q, data_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [AccW-1:0]             acc_adj;
  logic [AccW+VALUE_WIDTH-1:0] shift_w;
  logic [DIGITS-1:0]           en_calc;
  logic                        nz_above;

  // Add-3 correction on every digit in parallel before the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shift_w = {acc_adj, val_q} << 1;
  end

  // Digit i lit when any digit at or above it is nonzero; digit 0 always lit.
  always_comb begin
    nz_above = 1'b0;
    en_calc  = '0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      nz_above   = nz_above | (acc_q[4*i +: 4] != 4'd0);
      en_calc[i] = nz_above | (BLANK_LEADING == 0);
    end
    en_calc[0] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    data_d     = data_q;
    en_d       = en_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          val_d      = value_i;
          ovf_pend_d = (value_i > MaxVal);
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        acc_d = shift_w[AccW+VALUE_WIDTH-1:VALUE_WIDTH];
        val_d = shift_w[VALUE_WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        data_d  = ovf_pend_q ? '1 : acc_q;
        en_d    = ovf_pend_q ? '1 : en_calc;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      val_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      data_q     <= '0;
      en_q       <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      data_q     <= data_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign data_o            = data_q;
  assign display_enables_o = en_q & digit_mask_i;
  assign busy_o            = (state_q != StIdle);
  assign done_o            = done_q;
  assign overflow_o        = ovf_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Directed-vector and random-model bench for bcd_display_feeder.
module tb_bcd_display_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] value;
  logic [5:0]  mask;
  logic [23:0] data;
  logic [5:0]  en;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_vec  = 0;
  int n_fail = 0;

  bcd_display_feeder dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .value_i           (value),
    .digit_mask_i      (mask),
    .data_o            (data),
    .display_enables_o (en),
    .busy_o            (busy),
    .done_o            (done),
    .overflow_o        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] v;
    logic [5:0]  m;
    logic [23:0] exp_data;
    logic [5:0]  exp_en;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issues one Start and checks latency, result and single-cycle Done.
  task automatic run_conv(input string name, input logic [19:0] v, input logic [5:0] m,
                          input logic [23:0] ed, input logic [5:0] ee, input logic eo);
    int cyc;
    bit got;
    @(negedge clk);
    value = v;
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    check({name, " busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check({name, " latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'd21);
    check({name, " data"}, 32'(data), 32'(ed));
    check({name, " en"}, 32'(en), 32'(ee));
    check({name, " ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk);
    #1;
    check({name, " done pulse"}, 32'(done), 32'd0);
  endtask

  function automatic void model(input logic [19:0] v, input logic [5:0] m,
                                output logic [23:0] d, output logic [5:0] e,
                                output logic o);
    int unsigned x;
    bit seen;
    logic [5:0] raw;
    x = v;
    o = (v > 20'd999999);
    d = '0;
    for (int i = 0; i < 6; i++) begin
      d[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    seen = 1'b0;
    raw  = '0;
    for (int i = 5; i >= 0; i--) begin
      if (d[4*i +: 4] != 4'd0 || i == 0) seen = 1'b1;
      raw[i] = seen;
    end
    if (o) begin
      d   = 24'hFFFFFF;
      raw = 6'h3F;
    end
    e = raw & m;
  endfunction

  vec_t vecs[11];

  initial begin
    logic [23:0] md;
    logic [5:0]  me;
    logic        mo;
    logic [19:0] rv;
    logic [5:0]  rm;
    int          cyc;
    bit          got;

    vecs[0]  = '{20'd0,       6'h3F, 24'h000000, 6'b000001, 1'b0};
    vecs[1]  = '{20'd123456,  6'h3F, 24'h123456, 6'b111111, 1'b0};
    vecs[2]  = '{20'd1000,    6'h3F, 24'h001000, 6'b001111, 1'b0};
    vecs[3]  = '{20'd999999,  6'h3F, 24'h999999, 6'b111111, 1'b0};
    vecs[4]  = '{20'd1000000, 6'h3F, 24'hFFFFFF, 6'b111111, 1'b1};
    vecs[5]  = '{20'd1048575, 6'h3F, 24'hFFFFFF, 6'b111111, 1'b1};
    vecs[6]  = '{20'd9,       6'h3F, 24'h000009, 6'b000001, 1'b0};
    vecs[7]  = '{20'd10,      6'h3F, 24'h000010, 6'b000011, 1'b0};
    vecs[8]  = '{20'd100000,  6'h3F, 24'h100000, 6'b111111, 1'b0};
    vecs[9]  = '{20'd90,      6'h2A, 24'h000090, 6'b000010, 1'b0};
    vecs[10] = '{20'd123456,  6'h3F, 24'h123456, 6'b111111, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    mask  = 6'h3F;
    #12;
    check("reset data", 32'(data), 32'd0);
    check("reset en", 32'(en), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].v, vecs[i].m, vecs[i].exp_data,
               vecs[i].exp_en, vecs[i].exp_ovf);
    end

    // Mask is live; data holds.
    @(negedge clk);
    mask = 6'b000011;
    #1;
    check("live mask en", 32'(en), 32'h03);
    check("live mask data", 32'(data), 32'h123456);
    mask = 6'h3F;

    // Start held high, Value changed mid-conversion.
    @(negedge clk);
    value = 20'd42;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 43; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) value = 20'd7;
      if (i < 21 || (i > 21 && i < 43)) begin
        check($sformatf("held busy c%0d", i), 32'(busy), 32'd1);
        check($sformatf("held nodone c%0d", i), 32'(done), 32'd0);
      end else if (i == 21) begin
        check("held done1", 32'(done), 32'd1);
        check("held data1", 32'(data), 32'h000042);
        check("held busy idle", 32'(busy), 32'd0);
      end else begin
        check("held done2", 32'(done), 32'd1);
        check("held data2", 32'(data), 32'h000007);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);

    // Async reset mid-conversion.
    @(negedge clk);
    value = 20'd999;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst data", 32'(data), 32'd0);
    check("midrst en", 32'(en), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    check("midrst no done", 32'(got), 32'd0);
    run_conv("post rst", 20'd5, 6'h3F, 24'h000005, 6'b000001, 1'b0);

    // Random values against a division-based model.
    for (int n = 0; n < 1000; n++) begin
      rv = 20'($urandom_range(0, 1048575));
      rm = 6'($urandom);
      model(rv, rm, md, me, mo);
      run_conv($sformatf("rnd%0d v=%0d", n, rv), rv, rm, md, me, mo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
